or1k_marocchino_div_rsrvs: RTL and testbench



---
 rtl/or1k_marocchino_pkg.sv | 18 +
 rtl/or1k_marocchino_rsrvs_opnd.sv | 65 ++++++
 rtl/or1k_marocchino_div_rsrvs.sv | 127 ++++++++++++
 tb/tb_or1k_marocchino_div_rsrvs.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/or1k_marocchino_pkg.sv
// Shared definitions for the MAROCCHINO reservation stations: one-hot FSM state
// encodings and the default producer-tag width.
package or1k_marocchino_pkg;

  localparam int unsigned DEST_EXTADR_WIDTH_DEF = 3;
  localparam int unsigned RSRVS_STATE_W         = 3;

  localparam logic [RSRVS_STATE_W-1:0] RSRVS_EMPTY = 3'b001;
  localparam logic [RSRVS_STATE_W-1:0] RSRVS_WAIT  = 3'b010;
  localparam logic [RSRVS_STATE_W-1:0] RSRVS_READY = 3'b100;

  typedef enum logic [RSRVS_STATE_W-1:0] {
    ST_EMPTY = RSRVS_EMPTY,
    ST_WAIT  = RSRVS_WAIT,
    ST_READY = RSRVS_READY
  } rsrvs_state_e;

endpackage

// File: rtl/or1k_marocchino_rsrvs_opnd.sv
// One reservation-station operand: value, hazard flag and producer tag, plus the
// write-back snoop comparator. Optional macro: OR1K_MAROCCHINO_DIV_RSRVS_INSERT_SNOOP_EN.
module or1k_marocchino_rsrvs_opnd
  import or1k_marocchino_pkg::*;
#(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned DEST_EXTADR_WIDTH    = DEST_EXTADR_WIDTH_DEF
) (
  input  logic                            cpu_clk,
  input  logic                            cpu_rst,
  input  logic                            pipeline_flush_i,
  input  logic                            i_insert,
  input  logic                            i_wait,
  input  logic [OPTION_OPERAND_WIDTH-1:0] i_dcod_value,
  input  logic                            i_dcod_hazard,
  input  logic [DEST_EXTADR_WIDTH-1:0]    i_dcod_extadr,
  input  logic                            i_padv_wrbk,
  input  logic [DEST_EXTADR_WIDTH-1:0]    i_wrbk_extadr,
  input  logic [OPTION_OPERAND_WIDTH-1:0] i_wrbk_result,
  output logic [OPTION_OPERAND_WIDTH-1:0] o_value,
  output logic                            o_hazard_nxt_c
);

  logic [OPTION_OPERAND_WIDTH-1:0] r_value;
  logic                            r_hazard;
  logic [DEST_EXTADR_WIDTH-1:0]    r_extadr;
  logic                            w_ins_hit;
  logic                            w_snoop_hit;
  logic                            w_hazard_nxt;
  logic [OPTION_OPERAND_WIDTH-1:0] w_ins_value;

`ifdef OR1K_MAROCCHINO_DIV_RSRVS_INSERT_SNOOP_EN
  assign w_ins_hit = i_padv_wrbk & i_dcod_hazard & (i_dcod_extadr == i_wrbk_extadr);
`else
  assign w_ins_hit = 1'b0;
`endif

  assign w_ins_value = w_ins_hit ? i_wrbk_result : i_dcod_value;
  assign w_snoop_hit = i_wait & i_padv_wrbk & r_hazard & (r_extadr == i_wrbk_extadr);

  always_comb begin
    w_hazard_nxt = r_hazard;
    if (cpu_rst | pipeline_flush_i) w_hazard_nxt = 1'b0;
    else if (i_insert)              w_hazard_nxt = i_dcod_hazard & ~w_ins_hit;
    else if (w_snoop_hit)           w_hazard_nxt = 1'b0;
  end

  always_ff @(posedge cpu_clk) begin
    r_hazard <= w_hazard_nxt;
  end

  // Value and tag are not reset: they are only meaningful while the entry is valid.
  always_ff @(posedge cpu_clk) begin
    if (i_insert) begin
      r_value  <= w_ins_value;
      r_extadr <= i_dcod_extadr;
    end else if (w_snoop_hit) begin
      r_value  <= i_wrbk_result;
    end
  end

  assign o_value        = r_value;
  assign o_hazard_nxt_c = w_hazard_nxt;

endmodule

// File: rtl/or1k_marocchino_div_rsrvs.sv
// Single-entry reservation station in front of the serial integer divider.
// Optional macro: OR1K_MAROCCHINO_DIV_RSRVS_INSERT_SNOOP_EN (snoop in the insert cycle).
module or1k_marocchino_div_rsrvs
  import or1k_marocchino_pkg::*;
#(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned DEST_EXTADR_WIDTH    = DEST_EXTADR_WIDTH_DEF
) (
  input  logic                            cpu_clk,
  input  logic                            cpu_rst,
  input  logic                            pipeline_flush_i,
  input  logic                            padv_dcod_i,
  input  logic                            dcod_op_div_i,
  input  logic                            dcod_op_div_signed_i,
  input  logic                            dcod_op_div_unsigned_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dcod_rfa1_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dcod_rfb1_i,
  input  logic                            dcod_hazard_a1_i,
  input  logic                            dcod_hazard_b1_i,
  input  logic [DEST_EXTADR_WIDTH-1:0]    dcod_extadr_a1_i,
  input  logic [DEST_EXTADR_WIDTH-1:0]    dcod_extadr_b1_i,
  input  logic                            padv_wrbk_i,
  input  logic [DEST_EXTADR_WIDTH-1:0]    wrbk_extadr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wrbk_result_i,
  input  logic                            idiv_taking_op_i,
  output logic                            div_rsrvs_busy_o,
  output logic                            exec_op_div_o,
  output logic                            exec_op_div_signed_o,
  output logic                            exec_op_div_unsigned_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] exec_div_a1_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] exec_div_b1_o
);

  rsrvs_state_e r_state;
  rsrvs_state_e w_state_nxt;
  logic         r_busy;
  logic         r_exec;
  logic         r_signed;
  logic         r_unsigned;
  logic         w_kill;
  logic         w_insert;
  logic         w_wait;
  logic         w_haz_a_nxt;
  logic         w_haz_b_nxt;

  // Flush and reset dominate everything else in the same cycle.
  assign w_kill   = cpu_rst | pipeline_flush_i;
  assign w_insert = padv_dcod_i & dcod_op_div_i & ~r_busy & ~w_kill;
  assign w_wait   = (r_state == ST_WAIT) & ~w_kill;

  or1k_marocchino_rsrvs_opnd #(
    .OPTION_OPERAND_WIDTH (OPTION_OPERAND_WIDTH),
    .DEST_EXTADR_WIDTH    (DEST_EXTADR_WIDTH)
  ) u_opnd_a (
    .cpu_clk          (cpu_clk),
    .cpu_rst          (cpu_rst),
    .pipeline_flush_i (pipeline_flush_i),
    .i_insert         (w_insert),
    .i_wait           (w_wait),
    .i_dcod_value     (dcod_rfa1_i),
    .i_dcod_hazard    (dcod_hazard_a1_i),
    .i_dcod_extadr    (dcod_extadr_a1_i),
    .i_padv_wrbk      (padv_wrbk_i),
    .i_wrbk_extadr    (wrbk_extadr_i),
    .i_wrbk_result    (wrbk_result_i),
    .o_value          (exec_div_a1_o),
    .o_hazard_nxt_c   (w_haz_a_nxt)
  );

  or1k_marocchino_rsrvs_opnd #(
    .OPTION_OPERAND_WIDTH (OPTION_OPERAND_WIDTH),
    .DEST_EXTADR_WIDTH    (DEST_EXTADR_WIDTH)
  ) u_opnd_b (
    .cpu_clk          (cpu_clk),
    .cpu_rst          (cpu_rst),
    .pipeline_flush_i (pipeline_flush_i),
    .i_insert         (w_insert),
    .i_wait           (w_wait),
    .i_dcod_value     (dcod_rfb1_i),
    .i_dcod_hazard    (dcod_hazard_b1_i),
    .i_dcod_extadr    (dcod_extadr_b1_i),
    .i_padv_wrbk      (padv_wrbk_i),
    .i_wrbk_extadr    (wrbk_extadr_i),
    .i_wrbk_result    (wrbk_result_i),
    .o_value          (exec_div_b1_o),
    .o_hazard_nxt_c   (w_haz_b_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_EMPTY: if (w_insert) w_state_nxt = (w_haz_a_nxt | w_haz_b_nxt) ? ST_WAIT : ST_READY;
      ST_WAIT:  if (~w_haz_a_nxt & ~w_haz_b_nxt) w_state_nxt = ST_READY;
      ST_READY: if (idiv_taking_op_i) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Busy and ready are registered copies of the next state, so they match r_state.
  always_ff @(posedge cpu_clk) begin
    if (w_kill) begin
      r_state <= ST_EMPTY;
      r_busy  <= 1'b0;
      r_exec  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_EMPTY);
      r_exec  <= (w_state_nxt == ST_READY);
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (w_kill) begin
      r_signed   <= 1'b0;
      r_unsigned <= 1'b0;
    end else if (w_insert) begin
      r_signed   <= dcod_op_div_signed_i;
      r_unsigned <= dcod_op_div_unsigned_i;
    end
  end

  assign div_rsrvs_busy_o       = r_busy;
  assign exec_op_div_o          = r_exec;
  assign exec_op_div_signed_o   = r_signed;
  assign exec_op_div_unsigned_o = r_unsigned;

endmodule

// File: tb/tb_or1k_marocchino_div_rsrvs.sv
// Self-checking bench for or1k_marocchino_div_rsrvs; expected operations go into a
// scoreboard on insert and are compared when the divider takes them.
module tb_or1k_marocchino_div_rsrvs;

  localparam int unsigned OW = 32;
  localparam int unsigned EW = 3;

  typedef struct packed {
    logic          sgn;
    logic          usg;
    logic [OW-1:0] a;
    logic [OW-1:0] b;
  } exp_op_t;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst;
  logic          pipeline_flush_i;
  logic          padv_dcod_i;
  logic          dcod_op_div_i;
  logic          dcod_op_div_signed_i;
  logic          dcod_op_div_unsigned_i;
  logic [OW-1:0] dcod_rfa1_i;
  logic [OW-1:0] dcod_rfb1_i;
  logic          dcod_hazard_a1_i;
  logic          dcod_hazard_b1_i;
  logic [EW-1:0] dcod_extadr_a1_i;
  logic [EW-1:0] dcod_extadr_b1_i;
  logic          padv_wrbk_i;
  logic [EW-1:0] wrbk_extadr_i;
  logic [OW-1:0] wrbk_result_i;
  logic          idiv_taking_op_i;
  logic          div_rsrvs_busy_o;
  logic          exec_op_div_o;
  logic          exec_op_div_signed_o;
  logic          exec_op_div_unsigned_o;
  logic [OW-1:0] exec_div_a1_o;
  logic [OW-1:0] exec_div_b1_o;

  int      n_tests = 0;
  int      n_fail  = 0;
  int      n_illegal_ins = 0;
  exp_op_t sb_q[$];

  always #5 cpu_clk = ~cpu_clk;

  or1k_marocchino_div_rsrvs #(
    .OPTION_OPERAND_WIDTH (OW),
    .DEST_EXTADR_WIDTH    (EW)
  ) dut (
    .cpu_clk                (cpu_clk),
    .cpu_rst                (cpu_rst),
    .pipeline_flush_i       (pipeline_flush_i),
    .padv_dcod_i            (padv_dcod_i),
    .dcod_op_div_i          (dcod_op_div_i),
    .dcod_op_div_signed_i   (dcod_op_div_signed_i),
    .dcod_op_div_unsigned_i (dcod_op_div_unsigned_i),
    .dcod_rfa1_i            (dcod_rfa1_i),
    .dcod_rfb1_i            (dcod_rfb1_i),
    .dcod_hazard_a1_i       (dcod_hazard_a1_i),
    .dcod_hazard_b1_i       (dcod_hazard_b1_i),
    .dcod_extadr_a1_i       (dcod_extadr_a1_i),
    .dcod_extadr_b1_i       (dcod_extadr_b1_i),
    .padv_wrbk_i            (padv_wrbk_i),
    .wrbk_extadr_i          (wrbk_extadr_i),
    .wrbk_result_i          (wrbk_result_i),
    .idiv_taking_op_i       (idiv_taking_op_i),
    .div_rsrvs_busy_o       (div_rsrvs_busy_o),
    .exec_op_div_o          (exec_op_div_o),
    .exec_op_div_signed_o   (exec_op_div_signed_o),
    .exec_op_div_unsigned_o (exec_op_div_unsigned_o),
    .exec_div_a1_o          (exec_div_a1_o),
    .exec_div_b1_o          (exec_div_b1_o)
  );

  // Protocol watch: decode must never insert while the station is busy.
  always @(negedge cpu_clk) begin
    if (!cpu_rst && padv_dcod_i && dcod_op_div_i && div_rsrvs_busy_o)
      n_illegal_ins++;
  end

  // Scoreboard: compare the presented op against the oldest expectation on a take.
  always @(negedge cpu_clk) begin
    if (!cpu_rst && !pipeline_flush_i && exec_op_div_o && idiv_taking_op_i) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_take: take with empty scoreboard, a=%h b=%h", exec_div_a1_o, exec_div_b1_o);
      end else begin
        exp_op_t e;
        e = sb_q.pop_front();
        if ({exec_op_div_signed_o, exec_op_div_unsigned_o, exec_div_a1_o, exec_div_b1_o} !== e) begin
          n_fail++;
          $display("FAIL sb_take: got s=%b u=%b a=%h b=%h, want s=%b u=%b a=%h b=%h",
                   exec_op_div_signed_o, exec_op_div_unsigned_o, exec_div_a1_o, exec_div_b1_o,
                   e.sgn, e.usg, e.a, e.b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic drive_insert(input logic sgn, input logic [OW-1:0] a, input logic [OW-1:0] b,
                              input logic ha, input logic hb,
                              input logic [EW-1:0] ta, input logic [EW-1:0] tb);
    padv_dcod_i            = 1'b1;
    dcod_op_div_i          = 1'b1;
    dcod_op_div_signed_i   = sgn;
    dcod_op_div_unsigned_i = ~sgn;
    dcod_rfa1_i            = a;
    dcod_rfb1_i            = b;
    dcod_hazard_a1_i       = ha;
    dcod_hazard_b1_i       = hb;
    dcod_extadr_a1_i       = ta;
    dcod_extadr_b1_i       = tb;
  endtask

  task automatic clear_dcod();
    padv_dcod_i      = 1'b0;
    dcod_op_div_i    = 1'b0;
    dcod_hazard_a1_i = 1'b0;
    dcod_hazard_b1_i = 1'b0;
  endtask

  task automatic take_op();
    idiv_taking_op_i = 1'b1;
    tick();
    idiv_taking_op_i = 1'b0;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({div_rsrvs_busy_o, exec_op_div_o, exec_op_div_signed_o, exec_op_div_unsigned_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset: busy/exec/s/u=%b, want 0000",
               {div_rsrvs_busy_o, exec_op_div_o, exec_op_div_signed_o, exec_op_div_unsigned_o});
    end
    cpu_rst = 1'b0;
    tick();
  endtask

  task automatic test_hazard_free();
    drive_insert(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 3'd0, 3'd0);
    sb_q.push_back('{sgn: 1'b1, usg: 1'b0, a: 32'd100, b: 32'd7});
    tick();
    clear_dcod();
    n_tests++;
    if ({div_rsrvs_busy_o, exec_op_div_o, exec_op_div_signed_o} !== 3'b111 ||
        exec_div_a1_o !== 32'd100 || exec_div_b1_o !== 32'd7) begin
      n_fail++;
      $display("FAIL hazfree_ready: busy=%b exec=%b s=%b a=%0d b=%0d, want 1 1 1 100 7",
               div_rsrvs_busy_o, exec_op_div_o, exec_op_div_signed_o, exec_div_a1_o, exec_div_b1_o);
    end
    take_op();
    n_tests++;
    if ({div_rsrvs_busy_o, exec_op_div_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL hazfree_drain: busy=%b exec=%b, want 0 0", div_rsrvs_busy_o, exec_op_div_o);
    end
  endtask

  task automatic test_hazard_a();
    drive_insert(1'b1, 32'hDEAD_BEEF, 32'd2, 1'b1, 1'b0, 3'd3, 3'd0);
    sb_q.push_back('{sgn: 1'b1, usg: 1'b0, a: 32'hFFFF_FFF6, b: 32'd2});
    tick();
    clear_dcod();
    n_tests++;
    if ({div_rsrvs_busy_o, exec_op_div_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL hazA_wait: busy=%b exec=%b, want 1 0", div_rsrvs_busy_o, exec_op_div_o);
    end
    padv_wrbk_i = 1'b1; wrbk_extadr_i = 3'd2; wrbk_result_i = 32'h1234;
    tick();
    n_tests++;
    if (exec_op_div_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hazA_wrong_tag: exec=%b, want 0", exec_op_div_o);
    end
    wrbk_extadr_i = 3'd3; wrbk_result_i = 32'hFFFF_FFF6;
    tick();
    padv_wrbk_i = 1'b0;
    n_tests++;
    if (exec_op_div_o !== 1'b1 || exec_div_a1_o !== 32'hFFFF_FFF6 || exec_div_b1_o !== 32'd2) begin
      n_fail++;
      $display("FAIL hazA_resolve: exec=%b a=%h b=%h, want 1 fffffff6 00000002",
               exec_op_div_o, exec_div_a1_o, exec_div_b1_o);
    end
    take_op();
  endtask

  task automatic test_hazard_both();
    drive_insert(1'b0, 32'd1, 32'd1, 1'b1, 1'b1, 3'd5, 3'd5);
    sb_q.push_back('{sgn: 1'b0, usg: 1'b1, a: 32'd9, b: 32'd9});
    tick();
    clear_dcod();
    padv_wrbk_i = 1'b1; wrbk_extadr_i = 3'd5; wrbk_result_i = 32'd9;
    tick();
    padv_wrbk_i = 1'b0;
    n_tests++;
    if (exec_op_div_o !== 1'b1 || exec_op_div_unsigned_o !== 1'b1 ||
        exec_div_a1_o !== 32'd9 || exec_div_b1_o !== 32'd9) begin
      n_fail++;
      $display("FAIL hazAB_resolve: exec=%b u=%b a=%0d b=%0d, want 1 1 9 9",
               exec_op_div_o, exec_op_div_unsigned_o, exec_div_a1_o, exec_div_b1_o);
    end
    take_op();
  endtask

  task automatic test_insert_snoop();
    drive_insert(1'b1, 32'd0, 32'd4, 1'b1, 1'b0, 3'd4, 3'd0);
    padv_wrbk_i = 1'b1; wrbk_extadr_i = 3'd4; wrbk_result_i = 32'h55;
`ifdef OR1K_MAROCCHINO_DIV_RSRVS_INSERT_SNOOP_EN
    sb_q.push_back('{sgn: 1'b1, usg: 1'b0, a: 32'h55, b: 32'd4});
    tick();
    clear_dcod();
    padv_wrbk_i = 1'b0;
    n_tests++;
    if (exec_op_div_o !== 1'b1 || exec_div_a1_o !== 32'h55) begin
      n_fail++;
      $display("FAIL ins_snoop_on: exec=%b a=%h, want 1 00000055", exec_op_div_o, exec_div_a1_o);
    end
`else
    sb_q.push_back('{sgn: 1'b1, usg: 1'b0, a: 32'h66, b: 32'd4});
    tick();
    clear_dcod();
    padv_wrbk_i = 1'b0;
    n_tests++;
    if ({div_rsrvs_busy_o, exec_op_div_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL ins_snoop_off_wait: busy=%b exec=%b, want 1 0", div_rsrvs_busy_o, exec_op_div_o);
    end
    padv_wrbk_i = 1'b1; wrbk_extadr_i = 3'd4; wrbk_result_i = 32'h66;
    tick();
    padv_wrbk_i = 1'b0;
    n_tests++;
    if (exec_op_div_o !== 1'b1 || exec_div_a1_o !== 32'h66) begin
      n_fail++;
      $display("FAIL ins_snoop_off_late: exec=%b a=%h, want 1 00000066", exec_op_div_o, exec_div_a1_o);
    end
`endif
    take_op();
  endtask

  task automatic test_hold_ready();
    int ill0;
    drive_insert(1'b0, 32'd11, 32'd3, 1'b0, 1'b0, 3'd0, 3'd0);
    sb_q.push_back('{sgn: 1'b0, usg: 1'b1, a: 32'd11, b: 32'd3});
    tick();
    clear_dcod();
    ill0 = n_illegal_ins;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) drive_insert(1'b1, 32'd77, 32'd88, 1'b0, 1'b0, 3'd1, 3'd1);
      // Unrelated write-back traffic must not disturb a READY entry.
      padv_wrbk_i = 1'b1; wrbk_extadr_i = 3'd0; wrbk_result_i = 32'hBAD0 + 32'(i);
      tick();
      clear_dcod();
      padv_wrbk_i = 1'b0;
      n_tests++;
      if ({div_rsrvs_busy_o, exec_op_div_o, exec_op_div_signed_o, exec_op_div_unsigned_o} !== 4'b1101 ||
          exec_div_a1_o !== 32'd11 || exec_div_b1_o !== 32'd3) begin
        n_fail++;
        $display("FAIL hold_c%0d: busy/exec/s/u=%b a=%0d b=%0d, want 1101 11 3", i,
                 {div_rsrvs_busy_o, exec_op_div_o, exec_op_div_signed_o, exec_op_div_unsigned_o},
                 exec_div_a1_o, exec_div_b1_o);
      end
    end
    n_tests++;
    if (n_illegal_ins - ill0 !== 1) begin
      n_fail++;
      $display("FAIL hold_illegal_flag: flagged %0d inserts while busy, want 1", n_illegal_ins - ill0);
    end
    take_op();
  endtask

  task automatic test_flush_reset();
    drive_insert(1'b1, 32'd0, 32'd6, 1'b1, 1'b0, 3'd6, 3'd0);
    tick();
    clear_dcod();
    pipeline_flush_i = 1'b1; idiv_taking_op_i = 1'b1;
    padv_wrbk_i = 1'b1; wrbk_extadr_i = 3'd6; wrbk_result_i = 32'd12;
    tick();
    pipeline_flush_i = 1'b0; idiv_taking_op_i = 1'b0; padv_wrbk_i = 1'b0;
    n_tests++;
    if ({div_rsrvs_busy_o, exec_op_div_o, exec_op_div_signed_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL flush: busy/exec/s=%b, want 000", {div_rsrvs_busy_o, exec_op_div_o, exec_op_div_signed_o});
    end
    tick();
    n_tests++;
    if ({div_rsrvs_busy_o, exec_op_div_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_stays_empty: busy=%b exec=%b, want 0 0", div_rsrvs_busy_o, exec_op_div_o);
    end
    drive_insert(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 3'd0, 3'd2);
    tick();
    clear_dcod();
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    n_tests++;
    if ({div_rsrvs_busy_o, exec_op_div_o, exec_op_div_unsigned_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_midwait: busy/exec/u=%b, want 000", {div_rsrvs_busy_o, exec_op_div_o, exec_op_div_unsigned_o});
    end
    padv_wrbk_i = 1'b1; wrbk_extadr_i = 3'd2; wrbk_result_i = 32'd1;
    tick();
    padv_wrbk_i = 1'b0;
    n_tests++;
    if ({div_rsrvs_busy_o, exec_op_div_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_no_revive: busy=%b exec=%b, want 0 0", div_rsrvs_busy_o, exec_op_div_o);
    end
  endtask

  initial begin
    cpu_rst = 1'b1; pipeline_flush_i = 1'b0; idiv_taking_op_i = 1'b0;
    padv_dcod_i = 1'b0; dcod_op_div_i = 1'b0;
    dcod_op_div_signed_i = 1'b0; dcod_op_div_unsigned_i = 1'b0;
    dcod_rfa1_i = '0; dcod_rfb1_i = '0;
    dcod_hazard_a1_i = 1'b0; dcod_hazard_b1_i = 1'b0;
    dcod_extadr_a1_i = '0; dcod_extadr_b1_i = '0;
    padv_wrbk_i = 1'b0; wrbk_extadr_i = '0; wrbk_result_i = '0;

    test_reset();
    test_hazard_free();
    test_hazard_a();
    test_hazard_both();
    test_insert_snoop();
    test_hold_ready();
    test_flush_reset();

    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected ops never taken, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
